// File: rtl/load_if.sv
// Bundle of the load-stage signals: the upstream word handshake, the datapath
// status flags, the datapath control strobes and the rate-block handoff.
interface load_if #(
  parameter int BLOCK_CNT_W = 16
);
  logic                   valid_i;
  logic                   ready_o;
  logic                   input_buffer_full;
  logic                   input_size_reached;
  logic                   first_incomplete_input_word;
  logic                   last_input_block;
  logic                   control_regs_enable;
  logic                   load_enable;
  logic                   padding_enable;
  logic                   padding_reset;
  logic                   input_counter_en;
  logic                   input_counter_load;
  logic                   rate_valid_o;
  logic                   rate_ready_i;
  logic                   last_block_o;
  logic                   busy_o;
  logic [BLOCK_CNT_W-1:0] block_count_o;

  // Controller side: consumes status and handshakes, drives strobes.
  modport slave (
    input  valid_i, input_buffer_full, input_size_reached,
           first_incomplete_input_word, last_input_block, rate_ready_i,
    output ready_o, control_regs_enable, load_enable, padding_enable,
           padding_reset, input_counter_en, input_counter_load,
           rate_valid_o, last_block_o, busy_o, block_count_o
  );

  // Environment side: upstream source, datapath and absorb stage.
  modport master (
    output valid_i, input_buffer_full, input_size_reached,
           first_incomplete_input_word, last_input_block, rate_ready_i,
    input  ready_o, control_regs_enable, load_enable, padding_enable,
           padding_reset, input_counter_en, input_counter_load,
           rate_valid_o, last_block_o, busy_o, block_count_o
  );
endinterface

// File: rtl/load_control.sv
// Load-stage sequencer of the SHAKE core. Takes the header word and the
// message words, inserts padding-only words once the message is exhausted
// and hands each full rate block to the absorb stage.
module load_control #(
  parameter int BLOCK_CNT_W = 16
) (
  input  logic   clk,
  input  logic   rst,
  load_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PAD   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [BLOCK_CNT_W-1:0] block_count_r;

  logic ready_s;
  logic ctrl_en_s;
  logic load_en_s;
  logic pad_en_s;
  logic pad_rst_s;
  logic cnt_en_s;
  logic cnt_load_s;
  logic rate_valid_s;
  logic last_block_s;
  logic busy_s;
  logic count_clr_s;
  logic count_inc_s;

  // State register; reset abandons any partial block and returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Count of blocks handed off; cleared by a new header, wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_count_r <= {BLOCK_CNT_W{1'b0}};
    end else if (count_clr_s) begin
      block_count_r <= {BLOCK_CNT_W{1'b0}};
    end else if (count_inc_s) begin
      block_count_r <= block_count_r + BLOCK_CNT_W'(1);
    end else begin
      block_count_r <= block_count_r;
    end
  end

  // Next state and strobes; everything is held low while reset is asserted
  // so ready_o cannot advertise acceptance before the controller is live.
  always_comb begin
    state_nxt_s  = state_r;
    ready_s      = 1'b0;
    ctrl_en_s    = 1'b0;
    load_en_s    = 1'b0;
    pad_en_s     = 1'b0;
    pad_rst_s    = 1'b0;
    cnt_en_s     = 1'b0;
    cnt_load_s   = 1'b0;
    rate_valid_s = 1'b0;
    last_block_s = 1'b0;
    busy_s       = 1'b0;
    count_clr_s  = 1'b0;
    count_inc_s  = 1'b0;
    if (rst) begin
      busy_s = (state_r != IDLE);
      case (state_r)
        IDLE: begin
          ready_s = 1'b1;
          if (bus.valid_i) begin
            ctrl_en_s   = 1'b1;
            pad_rst_s   = 1'b1;
            cnt_load_s  = 1'b1;
            count_clr_s = 1'b1;
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOAD: begin
          // A full buffer takes priority over an exhausted message.
          if (bus.input_buffer_full) begin
            state_nxt_s = FLUSH;
          end else if (bus.input_size_reached) begin
            state_nxt_s = PAD;
          end else begin
            ready_s = 1'b1;
            if (bus.valid_i) begin
              load_en_s = 1'b1;
              cnt_en_s  = 1'b1;
              pad_en_s  = bus.first_incomplete_input_word;
            end else begin
              load_en_s = 1'b0;
            end
          end
        end
        PAD: begin
          if (bus.input_buffer_full) begin
            state_nxt_s = FLUSH;
          end else begin
            load_en_s = 1'b1;
            cnt_en_s  = 1'b1;
            pad_en_s  = 1'b1;
          end
        end
        FLUSH: begin
          // No strobes here so the buffered rate block stays stable.
          rate_valid_s = 1'b1;
          last_block_s = bus.last_input_block;
          if (bus.rate_ready_i) begin
            cnt_load_s  = 1'b1;
            count_inc_s = 1'b1;
            if (bus.last_input_block) begin
              state_nxt_s = IDLE;
            end else if (bus.input_size_reached) begin
              state_nxt_s = PAD;
            end else begin
              state_nxt_s = LOAD;
            end
          end else begin
            state_nxt_s = FLUSH;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
    end
  end

  assign bus.ready_o             = ready_s;
  assign bus.control_regs_enable = ctrl_en_s;
  assign bus.load_enable         = load_en_s;
  assign bus.padding_enable      = pad_en_s;
  assign bus.padding_reset       = pad_rst_s;
  assign bus.input_counter_en    = cnt_en_s;
  assign bus.input_counter_load  = cnt_load_s;
  assign bus.rate_valid_o        = rate_valid_s;
  assign bus.last_block_o        = last_block_s;
  assign bus.busy_o              = busy_s;
  assign bus.block_count_o       = block_count_r;

endmodule
